// File: rtl/cpu_sequencer_if.sv
// Control bus between the multicycle sequencer and the datapath/IR/RAM.
// go is a level release: while the sequencer sits in WAIT, a high go sampled
// on a rising edge starts the next fetch; go is ignored in every other state.
interface cpu_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [15:0]       C;
  logic              go;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              loadir;
  logic [2:0]        nsel;
  logic [1:0]        vsel;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic              write;
  logic [ADDR_W-1:0] pc;
  logic              retire;
  logic              halted;
  logic [4:0]        state;

  modport master (
    input  opcode, op, C, go,
    output mem_addr, mem_rd, mem_wr, loadir, nsel, vsel,
           loada, loadb, loadc, loads, asel, bsel, write,
           pc, retire, halted, state
  );

  modport slave (
    output opcode, op, C, go,
    input  mem_addr, mem_rd, mem_wr, loadir, nsel, vsel,
           loada, loadb, loadc, loads, asel, bsel, write,
           pc, retire, halted, state
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Moore control sequencer for the 16-bit RISC CPU: owns PC and the data-address
// register, and drives all datapath, IR and RAM strobes from the current state.
module cpu_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter bit                SINGLE_STEP = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  cpu_sequencer_if.master  bus
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPD_PC, S_DEC, S_WR_IMM, S_GET_A, S_GET_B, S_ALU,
    S_WR_REG, S_ADDR, S_LD_DA, S_MEM_RD, S_WR_MEM, S_GET_B_D, S_STR_WR,
    S_WAIT, S_HALT
  } state_t;

  // Instruction class is latched in DEC so later outputs depend on registers only.
  typedef enum logic [2:0] {
    K_MOVI, K_MOVR, K_ALU, K_CMP, K_LDR, K_STR, K_NONE
  } kind_t;

  state_t            state, state_n, done_n;
  kind_t             kind, dec_kind;
  logic [ADDR_W-1:0] pc_q, da_q;
  logic              msel;
  logic              unused_c;

  assign unused_c     = ^bus.C;
  assign bus.pc       = pc_q;
  assign bus.mem_addr = msel ? da_q : pc_q;
  assign bus.state    = state;
  assign done_n       = SINGLE_STEP ? S_WAIT : S_IF1;

  always_comb begin
    dec_kind = K_NONE;
    case (bus.opcode)
      3'b110: begin
        if (bus.op == 2'b10)      dec_kind = K_MOVI;
        else if (bus.op == 2'b00) dec_kind = K_MOVR;
      end
      3'b101: dec_kind = (bus.op == 2'b01) ? K_CMP : K_ALU;
      3'b011: if (bus.op == 2'b00) dec_kind = K_LDR;
      3'b100: if (bus.op == 2'b00) dec_kind = K_STR;
      default: dec_kind = K_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RST;
      kind  <= K_NONE;
      pc_q  <= RESET_PC;
      da_q  <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_RST: begin
          pc_q <= RESET_PC;
          da_q <= '0;
        end
        S_UPD_PC: pc_q <= pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        S_DEC:    kind <= dec_kind;
        S_LD_DA:  da_q <= bus.C[ADDR_W-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    msel       = 1'b0;
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.loadir = 1'b0;
    bus.nsel   = 3'b000;
    bus.vsel   = 2'b00;
    bus.loada  = 1'b0;
    bus.loadb  = 1'b0;
    bus.loadc  = 1'b0;
    bus.loads  = 1'b0;
    bus.asel   = 1'b0;
    bus.bsel   = 1'b0;
    bus.write  = 1'b0;
    bus.retire = 1'b0;
    bus.halted = 1'b0;
    case (state)
      S_RST: state_n = S_IF1;
      S_IF1: begin
        bus.mem_rd = 1'b1;
        state_n    = S_IF2;
      end
      S_IF2: begin
        bus.mem_rd = 1'b1;
        bus.loadir = 1'b1;
        state_n    = S_UPD_PC;
      end
      S_UPD_PC: state_n = S_DEC;
      S_DEC: begin
        case (dec_kind)
          K_MOVI:                     state_n = S_WR_IMM;
          K_MOVR:                     state_n = S_GET_B;
          K_ALU, K_CMP, K_LDR, K_STR: state_n = S_GET_A;
          default:                    state_n = S_HALT;
        endcase
      end
      S_WR_IMM: begin
        bus.nsel   = 3'b001;
        bus.vsel   = 2'b10;
        bus.write  = 1'b1;
        bus.retire = 1'b1;
        state_n    = done_n;
      end
      S_GET_A: begin
        bus.nsel  = 3'b001;
        bus.loada = 1'b1;
        state_n   = (kind == K_ALU || kind == K_CMP) ? S_GET_B : S_ADDR;
      end
      S_GET_B: begin
        bus.nsel  = 3'b100;
        bus.loadb = 1'b1;
        state_n   = S_ALU;
      end
      S_ALU: begin
        if (kind == K_CMP) begin
          bus.loads  = 1'b1;
          bus.retire = 1'b1;
          state_n    = done_n;
        end else begin
          bus.loadc = 1'b1;
          bus.asel  = (kind == K_MOVR);
          state_n   = S_WR_REG;
        end
      end
      S_WR_REG: begin
        bus.nsel   = 3'b010;
        bus.write  = 1'b1;
        bus.retire = 1'b1;
        state_n    = done_n;
      end
      S_ADDR: begin
        bus.bsel  = 1'b1;
        bus.loadc = 1'b1;
        state_n   = S_LD_DA;
      end
      S_LD_DA: state_n = (kind == K_LDR) ? S_MEM_RD : S_GET_B_D;
      S_MEM_RD: begin
        msel       = 1'b1;
        bus.mem_rd = 1'b1;
        state_n    = S_WR_MEM;
      end
      S_WR_MEM: begin
        msel       = 1'b1;
        bus.nsel   = 3'b010;
        bus.vsel   = 2'b11;
        bus.write  = 1'b1;
        bus.retire = 1'b1;
        state_n    = done_n;
      end
      S_GET_B_D: begin
        bus.nsel  = 3'b010;
        bus.loadb = 1'b1;
        state_n   = S_STR_WR;
      end
      S_STR_WR: begin
        msel       = 1'b1;
        bus.mem_wr = 1'b1;
        bus.retire = 1'b1;
        state_n    = done_n;
      end
      S_WAIT: if (bus.go) state_n = S_IF1;
      S_HALT: bus.halted = 1'b1;
      default: state_n = S_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: one free-running instance (RESET_PC=0x10)
// and one single-step instance (RESET_PC=0xFF) exercising every instruction path.
module tb_cpu_sequencer;

  typedef struct packed {
    logic [7:0] addr;
    logic rd, wr, ir, la, lb, lc, ls, as, bs, wf;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic [7:0] pc;
    logic ret, hlt;
  } snap_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.ADDR_W(8)) bus_a ();
  cpu_sequencer_if #(.ADDR_W(8)) bus_b ();

  cpu_sequencer #(.ADDR_W(8), .RESET_PC(8'h10), .SINGLE_STEP(1'b0)) u_a (
    .clk(clk), .reset(rst_a), .bus(bus_a));
  cpu_sequencer #(.ADDR_W(8), .RESET_PC(8'hFF), .SINGLE_STEP(1'b1)) u_b (
    .clk(clk), .reset(rst_b), .bus(bus_b));

  snap_t now_a, now_b;
  assign now_a = {bus_a.mem_addr, bus_a.mem_rd, bus_a.mem_wr, bus_a.loadir, bus_a.loada,
                  bus_a.loadb, bus_a.loadc, bus_a.loads, bus_a.asel, bus_a.bsel, bus_a.write,
                  bus_a.nsel, bus_a.vsel, bus_a.pc, bus_a.retire, bus_a.halted};
  assign now_b = {bus_b.mem_addr, bus_b.mem_rd, bus_b.mem_wr, bus_b.loadir, bus_b.loada,
                  bus_b.loadb, bus_b.loadc, bus_b.loads, bus_b.asel, bus_b.bsel, bus_b.write,
                  bus_b.nsel, bus_b.vsel, bus_b.pc, bus_b.retire, bus_b.halted};

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  snap_t      rec[0:20];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic snap_t cur(input bit b);
    return b ? now_b : now_a;
  endfunction

  // strobe vector: rd wr ir la lb lc ls as bs wf
  function automatic logic [9:0] strb(input snap_t s);
    return {s.rd, s.wr, s.ir, s.la, s.lb, s.lc, s.ls, s.as, s.bs, s.wf};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered while in IF1; records one snapshot per cycle (rec[1] = IF1) until retire.
  task automatic run_instr(input bit b, input logic [2:0] opc, input logic [1:0] opv,
                           input logic [15:0] cval, input bit hold, output int len);
    int         cyc;
    snap_t      s;
    logic [7:0] exp_pc;
    if (b) begin
      bus_b.opcode = opc; bus_b.op = opv; bus_b.C = cval;
    end else begin
      bus_a.opcode = opc; bus_a.op = opv; bus_a.C = cval;
    end
    for (int i = 0; i <= 20; i++) rec[i] = '0;
    cyc    = 1;
    s      = cur(b);
    rec[1] = s;
    while (!s.ret && cyc < 16) begin
      step(1);
      cyc++;
      s        = cur(b);
      rec[cyc] = s;
    end
    len = s.ret ? cyc : 0;
    if (exp_q.size() > 0) exp_pc = exp_q.pop_front();
    else                  exp_pc = 'x;
    check("dec_pc", {24'h0, rec[4].pc}, {24'h0, exp_pc});
    if (s.ret && !hold) step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int len, nwr, bad;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.opcode = 3'b000; bus_a.op = 2'b00; bus_a.C = 16'h0; bus_a.go = 1'b0;
    bus_b.opcode = 3'b000; bus_b.op = 2'b00; bus_b.C = 16'h0; bus_b.go = 1'b0;
    #1;
    check("rst_pc",       now_a.pc, 8'h10);
    check("rst_mem_addr", now_a.addr, 8'h10);
    check("rst_strobes",  strb(now_a), 10'h0);
    check("rst_sel",      {now_a.nsel, now_a.vsel}, 5'h0);
    check("rst_ret_hlt",  {now_a.ret, now_a.hlt}, 2'b00);
    check("rst_pc_b",     now_b.pc, 8'hFF);
    step(2);
    check("rst_hold_pc",  now_a.pc, 8'h10);
    rst_a = 1'b0;
    step(1);
    check("first_fetch",  {now_a.addr, strb(now_a)}, {8'h10, 10'b1000000000});

    for (int p = 8'h11; p <= 8'h17; p++) exp_q.push_back(p[7:0]);

    // MOV imm
    run_instr(1'b0, 3'b110, 2'b10, 16'h0, 1'b0, len);
    check("movi_len",  len, 5);
    check("movi_if2",  strb(rec[2]), 10'b1010000000);
    check("movi_upd",  rec[3].pc, 8'h10);
    check("movi_dec",  strb(rec[4]), 10'h0);
    check("movi_wr",   {rec[5].nsel, rec[5].vsel, strb(rec[5]), rec[5].ret},
                       {3'b001, 2'b10, 10'b0000000001, 1'b1});
    // MOV reg
    run_instr(1'b0, 3'b110, 2'b00, 16'h0, 1'b0, len);
    check("movr_len",  len, 7);
    check("movr_if1",  strb(rec[1]), 10'b1000000000);
    check("movr_getb", {rec[5].nsel, strb(rec[5])}, {3'b100, 10'b0000100000});
    check("movr_alu",  strb(rec[6]), 10'b0000010100);
    check("movr_wr",   {rec[7].nsel, rec[7].vsel, strb(rec[7]), rec[7].ret},
                       {3'b010, 2'b00, 10'b0000000001, 1'b1});
    // CMP
    run_instr(1'b0, 3'b101, 2'b01, 16'h0, 1'b0, len);
    check("cmp_len",   len, 7);
    check("cmp_geta",  {rec[5].nsel, strb(rec[5])}, {3'b001, 10'b0001000000});
    check("cmp_alu",   {strb(rec[7]), rec[7].ret}, {10'b0000001000, 1'b1});
    // ADD
    run_instr(1'b0, 3'b101, 2'b00, 16'h0, 1'b0, len);
    check("add_len",   len, 8);
    check("add_alu",   strb(rec[7]), 10'b0000010000);
    check("add_wr",    {rec[8].nsel, rec[8].vsel, strb(rec[8]), rec[8].ret},
                       {3'b010, 2'b00, 10'b0000000001, 1'b1});
    // LDR
    run_instr(1'b0, 3'b011, 2'b00, 16'h1F25, 1'b0, len);
    check("ldr_len",   len, 9);
    check("ldr_fetch", rec[1].addr, 8'h14);
    check("ldr_addr",  strb(rec[6]), 10'b0000010010);
    check("ldr_ldda",  strb(rec[7]), 10'h0);
    check("ldr_memrd", {rec[8].addr, strb(rec[8])}, {8'h25, 10'b1000000000});
    check("ldr_wr",    {rec[9].addr, rec[9].nsel, rec[9].vsel, strb(rec[9]), rec[9].ret},
                       {8'h25, 3'b010, 2'b11, 10'b0000000001, 1'b1});
    // STR
    run_instr(1'b0, 3'b100, 2'b00, 16'h0033, 1'b0, len);
    check("str_len",   len, 9);
    check("str_getbd", {rec[8].nsel, strb(rec[8])}, {3'b010, 10'b0000100000});
    check("str_wr",    {rec[9].addr, strb(rec[9]), rec[9].ret}, {8'h33, 10'b0100000000, 1'b1});
    nwr = 0;
    for (int i = 1; i <= 9; i++) nwr += int'(rec[i].wr);
    check("str_wr_once", nwr, 1);
    // STR interrupted by reset in STR_WR
    run_instr(1'b0, 3'b100, 2'b00, 16'h0042, 1'b1, len);
    check("strr_wr",   {rec[9].addr, rec[9].wr}, {8'h42, 1'b1});
    rst_a = 1'b1;
    #1;
    check("strr_drop", {strb(now_a), now_a.ret}, 11'h0);
    check("strr_pc",   {now_a.pc, now_a.addr}, {8'h10, 8'h10});
    step(1);
    rst_a = 1'b0;
    step(1);
    // HALT
    bus_a.opcode = 3'b111; bus_a.op = 2'b00;
    step(3);
    check("halt_dec",  {now_a.hlt, now_a.pc}, {1'b0, 8'h11});
    step(1);
    check("halt_on",   {now_a.hlt, strb(now_a)}, {1'b1, 10'h0});
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (now_a.pc !== 8'h11 || now_a.ret !== 1'b0 || now_a.hlt !== 1'b1) bad++;
    end
    check("halt_hold", bad, 0);
    rst_a = 1'b1;
    #1;
    check("halt_clr",  {now_a.hlt, now_a.pc}, {1'b0, 8'h10});
    step(1);
    rst_a = 1'b0;
    step(1);
    // undefined encoding halts too
    bus_a.opcode = 3'b110; bus_a.op = 2'b01;
    step(4);
    check("undef_halt", now_a.hlt, 1'b1);

    // ---------------- single-step instance ----------------
    rst_b = 1'b0;
    step(1);
    check("ss_fetch",  {now_b.addr, strb(now_b)}, {8'hFF, 10'b1000000000});
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    run_instr(1'b1, 3'b100, 2'b00, 16'hAB12, 1'b0, len);
    check("ss_str_len", len, 9);
    check("ss_str_wr",  {rec[9].addr, rec[9].wr}, {8'h12, 1'b1});
    for (int i = 0; i < 5; i++) begin
      check("wait_idle", {strb(now_b), now_b.nsel, now_b.vsel, now_b.ret, now_b.pc},
                         {10'h0, 3'b000, 2'b00, 1'b0, 8'h00});
      step(1);
    end
    bus_b.go = 1'b1;
    step(1);
    check("go_fetch",  {now_b.addr, strb(now_b)}, {8'h00, 10'b1000000000});
    run_instr(1'b1, 3'b101, 2'b00, 16'h0, 1'b0, len);
    check("ss_add_len", len, 8);
    check("go_held_wait", {strb(now_b), now_b.ret}, 11'h0);
    step(1);
    check("go_held_fetch", {now_b.addr, strb(now_b)}, {8'h01, 10'b1000000000});
    bus_b.go = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
